alu_result_capture: RTL and testbench



---
 rtl/alu_result_capture_pkg.sv | 31 +++
 rtl/alu_result_capture_seg7_hex.sv | 31 +++
 rtl/alu_result_capture.sv | 137 +++++++++++++
 tb/tb_alu_result_capture.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_capture_pkg.sv
// Shared types and constants for the ALU result capture block: FSM states and
// active-low seven-segment glyphs (gfedcba bit order).
package alu_result_capture_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;  // lowercase b
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;  // lowercase d
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/alu_result_capture_seg7_hex.sv
// seg7_hex: combinational nibble to active-low seven-segment decoder.
module seg7_hex
  import alu_result_capture_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/alu_result_capture.sv
// Debounced pushbutton capture of ALUOut into a held result shown on LEDR/HEX.
// Optional ALU_CAPTURE_PREV_EN adds HEX2/HEX3 showing the previously held result.
//
//   state      | meaning
//   IDLE       | button released and stable, waiting for a press
//   PRESS_DB   | button low, counting stable-low cycles before capture
//   HELD       | captured; waiting for the button to be released
//   RELEASE_DB | button high, counting stable-high cycles before re-arming
module alu_result_capture
  import alu_result_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [7:0] ALUOut,
  input  logic       Capture_n,
  output logic [7:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
`ifdef ALU_CAPTURE_PREV_EN
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
`endif
  output logic       Valid,
  output logic [3:0] CapCount
);

  // Press terminal count places the capture on edge 2+DEBOUNCE_CYCLES after
  // the first edge that samples the raw button low.
  localparam logic [CNT_W-1:0] PRESS_TC   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] RELEASE_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             btn_s;
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             capture;
  logic [7:0]       result;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1 <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      sync1 <= Capture_n;
      btn_s <= sync1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!btn_s) begin
          state_next = PRESS_DB;
          cnt_next   = CNT_W'(1);
        end
      end
      PRESS_DB: begin
        if (btn_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == PRESS_TC) begin
          state_next = HELD;
          cnt_next   = '0;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (btn_s) begin
          state_next = RELEASE_DB;
          cnt_next   = CNT_W'(1);
        end
      end
      RELEASE_DB: begin
        if (!btn_s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt == RELEASE_TC) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      result   <= 8'h00;
      Valid    <= 1'b0;
      CapCount <= 4'd0;
    end else if (capture) begin
      result   <= ALUOut;
      Valid    <= 1'b1;
      CapCount <= CapCount + 4'd1;
    end
  end

  assign LEDR = result;

  seg7_hex u_hex0 (.nibble(result[3:0]), .seg(HEX0));
  seg7_hex u_hex1 (.nibble(result[7:4]), .seg(HEX1));

`ifdef ALU_CAPTURE_PREV_EN
  logic [7:0] prev;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      prev <= 8'h00;
    end else if (capture) begin
      prev <= result;
    end
  end

  seg7_hex u_hex2 (.nibble(prev[3:0]), .seg(HEX2));
  seg7_hex u_hex3 (.nibble(prev[7:4]), .seg(HEX3));
`endif

endmodule

// File: tb/tb_alu_result_capture.sv
// Scoreboard bench for alu_result_capture: stimulus queues expected captures,
// a negedge monitor pops and compares whenever CapCount advances.
module tb_alu_result_capture;

  localparam int DB = 4;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic [7:0] ALUOut = 8'h00;
  logic       Capture_n = 1'b1;
  logic [7:0] LEDR;
  logic [6:0] HEX0, HEX1;
`ifdef ALU_CAPTURE_PREV_EN
  logic [6:0] HEX2, HEX3;
`endif
  logic       Valid;
  logic [3:0] CapCount;

  alu_result_capture #(.DEBOUNCE_CYCLES(DB), .CNT_W(20)) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .ALUOut(ALUOut),
    .Capture_n(Capture_n),
    .LEDR(LEDR),
    .HEX0(HEX0),
    .HEX1(HEX1),
`ifdef ALU_CAPTURE_PREV_EN
    .HEX2(HEX2),
    .HEX3(HEX3),
`endif
    .Valid(Valid),
    .CapCount(CapCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] res;
    logic [7:0] prev;
    logic [3:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [3:0] exp_cnt = 4'd0;
  logic [7:0] last_res = 8'h00;
  logic [3:0] prev_cnt = 4'd0;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [7:0] wrap_vals [16] = '{
    8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
    8'hF0, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12
  };

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge Clock) begin
    if (!Resetn) begin
      prev_cnt = 4'd0;
    end else if (CapCount !== prev_cnt) begin
      prev_cnt = CapCount;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_capture actual LEDR=%0h CapCount=%0d required none", LEDR, CapCount);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("cap_edge", cyc, e.cyc);
        check("cap_ledr", {24'd0, LEDR}, {24'd0, e.res});
        check("cap_hex0", {25'd0, HEX0}, {25'd0, glyph[e.res[3:0]]});
        check("cap_hex1", {25'd0, HEX1}, {25'd0, glyph[e.res[7:4]]});
        check("cap_valid", {31'd0, Valid}, 32'd1);
        check("cap_count", {28'd0, CapCount}, {28'd0, e.cnt});
`ifdef ALU_CAPTURE_PREV_EN
        check("cap_hex2", {25'd0, HEX2}, {25'd0, glyph[e.prev[3:0]]});
        check("cap_hex3", {25'd0, HEX3}, {25'd0, glyph[e.prev[7:4]]});
`endif
      end
    end
  end

  // Called #1 after a posedge with Capture_n already low; next edge is edge 0.
  task automatic expect_capture(input logic [7:0] val);
    exp_t e;
    exp_cnt  = exp_cnt + 4'd1;
    e.res    = val;
    e.prev   = last_res;
    e.cnt    = exp_cnt;
    e.cyc    = cyc + 1 + 2 + DB;
    last_res = val;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge Clock);
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL capture_timeout actual pending=%0d required 0", q.size());
      q.delete();
    end
  endtask

  task automatic release_btn();
    @(posedge Clock);
    #1 Capture_n = 1'b1;
    repeat (DB + 5) @(posedge Clock);
  endtask

  task automatic press_capture(input logic [7:0] val);
    @(posedge Clock);
    #1;
    ALUOut    = val;
    Capture_n = 1'b0;
    expect_capture(val);
    wait_drain();
    release_btn();
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge Clock);
    #3 Resetn = 1'b0;
    #1;
    check({tag, "_ledr"}, {24'd0, LEDR}, 32'h00);
    check({tag, "_hex0"}, {25'd0, HEX0}, 32'h40);
    check({tag, "_hex1"}, {25'd0, HEX1}, 32'h40);
    check({tag, "_valid"}, {31'd0, Valid}, 32'd0);
    check({tag, "_count"}, {28'd0, CapCount}, 32'd0);
    @(posedge Clock);
    #1 Resetn = 1'b1;
    exp_cnt  = 4'd0;
    last_res = 8'h00;
  endtask

  initial begin
    #1;
    check("rst_ledr", {24'd0, LEDR}, 32'h00);
    check("rst_hex0", {25'd0, HEX0}, 32'h40);
    check("rst_hex1", {25'd0, HEX1}, 32'h40);
    check("rst_valid", {31'd0, Valid}, 32'd0);
    check("rst_count", {28'd0, CapCount}, 32'd0);
    repeat (3) @(posedge Clock);
    #1 Resetn = 1'b1;
    repeat (2) @(posedge Clock);

    // Clean press
    press_capture(8'h0F);

    // Bounce rejection
    for (int r = 0; r < 3; r++) begin
      @(posedge Clock);
      #1 Capture_n = 1'b0;
      ALUOut = 8'h99;
      repeat (2) @(posedge Clock);
      #1 Capture_n = 1'b1;
      @(posedge Clock);
    end
    repeat (10) @(posedge Clock);
    #1;
    check("bounce_ledr", {24'd0, LEDR}, 32'h0F);
    check("bounce_count", {28'd0, CapCount}, 32'd1);
    check("bounce_pending", q.size(), 32'd0);

    async_reset_check("midrst");

    // Hold then change ALUOut
    @(posedge Clock);
    #1;
    ALUOut    = 8'hA5;
    Capture_n = 1'b0;
    expect_capture(8'hA5);
    wait_drain();
    ALUOut = 8'h3C;
    repeat (50) @(posedge Clock);
    #1;
    check("hold_ledr", {24'd0, LEDR}, 32'hA5);
    check("hold_hex0", {25'd0, HEX0}, {25'd0, glyph[5]});
    check("hold_count", {28'd0, CapCount}, 32'd1);
    release_btn();
    press_capture(8'h3C);
    check("second_count", {28'd0, CapCount}, 32'd2);

    async_reset_check("prewrap");

    // Wrap of CapCount
    for (int i = 0; i < 16; i++) press_capture(wrap_vals[i]);
    check("wrap_count", {28'd0, CapCount}, 32'd0);
    check("wrap_valid", {31'd0, Valid}, 32'd1);
    check("wrap_ledr", {24'd0, LEDR}, 32'h12);

    // Reset while in PRESS_DB with counter at 2
    @(posedge Clock);
    #1;
    ALUOut    = 8'h7E;
    Capture_n = 1'b0;
    repeat (4) @(posedge Clock);
    #1 Resetn = 1'b0;
    #1;
    check("pressrst_valid", {31'd0, Valid}, 32'd0);
    check("pressrst_ledr", {24'd0, LEDR}, 32'h00);
    repeat (3) @(posedge Clock);
    #1 Resetn = 1'b1;
    exp_cnt  = 4'd0;
    last_res = 8'h00;
    expect_capture(8'h7E);
    wait_drain();
    release_btn();
    check("final_count", {28'd0, CapCount}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
